conv_window_gen: RTL and testbench
==================================

Name: conv_window_gen

Overview:
- Producer for the convolution engine input bus: converts a raster pixel stream (all CL_IN channels per pixel) into KERNEL x KERNEL sliding windows.
- Output bus packing and enable timing match what the CE consumes on data2conv/en_in.
- Sits between the feature-map source (previous layer or input DMA) and the CE array.
- Uses KERNEL-1 line buffers per channel plus a KERNEL x KERNEL window register; emits only fully-valid windows (no padding, stride 1).

Parameters:
- CL_IN, 8, number of input channels per pixel (2...64)
- KERNEL, 3, window size (1/3/5/7)
- N, 4, data width per channel sample
- IMG_W, 32, frame width in pixels (>= KERNEL)
- IMG_H, 32, frame height in pixels (>= KERNEL)

Ports:
- clk, input, 1, clock
- rst, input, 1, synchronous active-high reset
- d_in, input, CL_IN*N, one pixel; channel i at [i*N +: N]
- en_in, input, 1, d_in valid this cycle
- sof, input, 1, start of frame; sampled only with en_in; marks the current pixel as (row 0, col 0)
- data2conv, output, CL_IN*KERNEL*KERNEL*N, window; channel i at [i*K*K*N +: K*K*N]; tap (r,c) at channel offset (r*K+c)*N
- en_out, output, 1, data2conv valid (single-cycle per window)
- last_out, output, 1, asserted with en_out on the final window of the frame

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - col/row counters = 0.
  - data2conv, en_out and last_out = 0.
  - Line buffer and window contents need not be cleared; the row/col gating guarantees stale data is never emitted.
- Pixel coordinates:
  - Each en_in cycle consumes one pixel at (y,x).
  - x increments and wraps at IMG_W-1 to 0, incrementing y.
  - y wraps at IMG_H-1 to 0.
  - en_in=0: no state change; en_out=0 next cycle. Gaps are allowed anywhere.
- sof with en_in: the pixel is treated as (0,0) regardless of counters. Counters continue from (0,1). Any partially-built windows are abandoned.
- Line buffers:
  - KERNEL-1 buffers, each IMG_W deep x CL_IN*N wide, addressed by x.
  - On en_in, buffer k receives the value buffer k-1 held at x; buffer 0 receives d_in.
  - The result is that the column at x holds pixels (y-K+1..y, x).
- Window register:
  - On en_in, window columns shift left (c -> c-1).
  - Column K-1 is loaded with the new vertical column: r=K-1 is d_in, r=0 is the oldest row.
  - Tap (r,c) = pixel(y-K+1+r, x-K+1+c).
- Output timing:
  - Latency is 1 cycle: en_out is registered and asserted the cycle after an en_in where y >= K-1 and x >= K-1.
  - data2conv updates in the same cycle and holds until the next window.
  - last_out = en_out AND pixel was (IMG_H-1, IMG_W-1).
  - Windows per frame = (IMG_H-K+1)*(IMG_W-K+1).
- KERNEL=1: no line buffers; every pixel yields a window with 1-cycle latency.
- Row-boundary windows are never emitted: x < K-1 at the start of each row suppresses en_out.
- Simultaneous rst and en_in: rst wins; the pixel is dropped.
- Reset mid-frame: the first en_in after reset is (0,0) whether or not sof is asserted.
- Frame-to-frame: back-to-back frames with no idle cycles are supported. Line buffer contents from the prior frame are masked by the y < K-1 gating.

Test Plan:
- Basic frame:
  - Setup: CL_IN=2, K=3, N=4, IMG_W=5, IMG_H=4. ch0 = (y*5+x) mod 16, ch1 = 15-ch0. en_in continuous.
  - Expect first en_out 1 cycle after pixel 12 (y=2,x=2).
  - ch0 taps row0 = 0,1,2; row1 = 5,6,7; row2 = 10,11,12. ch1 taps row0 = 15,14,13.
- Window count/last:
  - Same frame as above.
  - Expect exactly 6 en_out pulses, at pixels 12,13,14,17,18,19.
  - last_out only on the 6th, with ch0 tap(2,2) = 3 (19 mod 16).
- Bubbles: same frame with en_in toggling 1,0,0,1 pattern.
  - Expect identical window sequence and values.
  - en_out never asserted in consecutive cycles where the source pixel had no en_in.
- Reset mid-frame:
  - rst for 1 cycle after pixel 8, then restart the stream from pixel 0.
  - Expect no en_out until the new pixel 12; windows identical to the basic frame.
- sof resync: assert sof on a pixel at counter position (1,3).
  - Expect that pixel treated as (0,0); next en_out after 12 further pixels.
  - Back-to-back second frame produces 6 windows again.
- K=1 case: IMG_W=4, IMG_H=2.
  - Expect 8 en_out pulses, each data2conv equal to the previous cycle's d_in.
  - last_out on the 8th pulse.

Source files
------------

// File: rtl/conv_window_gen.sv
// rtl/conv_window_gen.sv - raster pixel stream to KERNEL x KERNEL sliding-window generator
module conv_window_gen #(
    parameter int CL_IN  = 8,
    parameter int KERNEL = 3,
    parameter int N      = 4,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [CL_IN*N-1:0]               d_in,
    input  logic                             en_in,
    input  logic                             sof,
    output logic [CL_IN*KERNEL*KERNEL*N-1:0] data2conv,
    output logic                             en_out,
    output logic                             last_out
);
    localparam int PW = CL_IN * N;
    localparam int KK = KERNEL * KERNEL;
    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);

    logic [XW-1:0]      x_q, x_d, x_cur;
    logic [YW-1:0]      y_q, y_d, y_cur;
    logic               emit;
    logic               frame_end;
    logic [PW-1:0]      col_new [KERNEL];
    logic [PW-1:0]      win_q   [KERNEL][KERNEL];
    logic [PW-1:0]      win_d   [KERNEL][KERNEL];
    logic [PW*KK-1:0]   data_q, data_d;
    logic               en_q, last_q;

    // sof forces the current pixel to (0,0) no matter where the counters are
    always_comb begin
        x_cur = sof ? '0 : x_q;
        y_cur = sof ? '0 : y_q;
        x_d   = x_q;
        y_d   = y_q;
        if (en_in) begin
            if (x_cur == X_LAST) begin
                x_d = '0;
                y_d = (y_cur == Y_LAST) ? '0 : y_cur + 1'b1;
            end else begin
                x_d = x_cur + 1'b1;
                y_d = y_cur;
            end
        end
        emit      = en_in && (int'(x_cur) >= KERNEL - 1) && (int'(y_cur) >= KERNEL - 1);
        frame_end = (x_cur == X_LAST) && (y_cur == Y_LAST);
    end

    generate
        if (KERNEL > 1) begin : g_lb
            logic [PW-1:0] lb_q [KERNEL-1][IMG_W];

            always_ff @(posedge clk) begin
                if (en_in && !rst) begin
                    lb_q[0][x_cur] <= d_in;
                    for (int k = 1; k < KERNEL - 1; k++) begin
                        lb_q[k][x_cur] <= lb_q[k-1][x_cur];
                    end
                end
            end

            // buffer k holds row y-1-k, so the oldest row feeds window row 0
            for (genvar r = 0; r < KERNEL - 1; r++) begin : g_tap
                assign col_new[r] = lb_q[KERNEL-2-r][x_cur];
            end
        end
    endgenerate

    assign col_new[KERNEL-1] = d_in;

    always_comb begin
        for (int r = 0; r < KERNEL; r++) begin
            for (int c = 0; c < KERNEL - 1; c++) begin
                win_d[r][c] = win_q[r][c+1];
            end
            win_d[r][KERNEL-1] = col_new[r];
        end
    end

    always_comb begin
        data_d = '0;
        for (int i = 0; i < CL_IN; i++) begin
            for (int r = 0; r < KERNEL; r++) begin
                for (int c = 0; c < KERNEL; c++) begin
                    data_d[i*KK*N + (r*KERNEL+c)*N +: N] = win_d[r][c][i*N +: N];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (en_in && !rst) begin
            win_q <= win_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            data_q <= '0;
            en_q   <= 1'b0;
            last_q <= 1'b0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            en_q   <= emit;
            last_q <= emit && frame_end;
            if (emit) begin
                data_q <= data_d;
            end
        end
    end

    assign data2conv = data_q;
    assign en_out    = en_q;
    assign last_out  = last_q;
endmodule

// File: tb/tb_conv_window_gen.sv
// tb/tb_conv_window_gen.sv - directed table-driven bench for conv_window_gen (K=3 and K=1 instances)
module tb_conv_window_gen;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  d_in;
    logic        en_in, sof;
    logic [71:0] data2conv;
    logic        en_out, last_out;
    logic [7:0]  d1;
    logic        en1, sof1;
    logic [7:0]  data1;
    logic        en_out1, last_out1;

    always #5 clk = ~clk;

    conv_window_gen #(.CL_IN(2), .KERNEL(3), .N(4), .IMG_W(5), .IMG_H(4)) dut (
        .clk(clk), .rst(rst), .d_in(d_in), .en_in(en_in), .sof(sof),
        .data2conv(data2conv), .en_out(en_out), .last_out(last_out)
    );

    conv_window_gen #(.CL_IN(2), .KERNEL(1), .N(4), .IMG_W(4), .IMG_H(2)) dut1 (
        .clk(clk), .rst(rst), .d_in(d1), .en_in(en1), .sof(sof1),
        .data2conv(data1), .en_out(en_out1), .last_out(last_out1)
    );

    typedef struct {
        int         pix;
        bit         last;
        logic [3:0] t00;
        logic [3:0] t22;
        logic [3:0] c1t00;
    } vec_t;

    vec_t tbl [6];
    int   nvec = 0;
    int   nerr = 0;
    int   widx;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] model(input int y, input int x);
        logic [71:0] m;
        m = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                int v;
                v = ((y - 2 + r) * 5 + (x - 2 + c)) % 16;
                m[(r*3+c)*4 +: 4]      = 4'(v);
                m[36 + (r*3+c)*4 +: 4] = 4'(15 - v);
            end
        end
        return m;
    endfunction

    task automatic send(input int p, input bit s, input int idle);
        int y, x;
        bit emit;
        y = p / 5;
        x = p % 5;
        d_in  = {4'(15 - p % 16), 4'(p % 16)};
        en_in = 1'b1;
        sof   = s;
        @(posedge clk);
        #1;
        en_in = 1'b0;
        sof   = 1'b0;
        emit  = (y >= 2) && (x >= 2);
        chk($sformatf("en_out p%0d", p), 72'(en_out), 72'(emit));
        if (emit) begin
            chk($sformatf("window p%0d", p), data2conv, model(y, x));
            if (widx < 6) begin
                chk($sformatf("tbl pix w%0d", widx), 72'(p), 72'(tbl[widx].pix));
                chk($sformatf("tbl t00 w%0d", widx), 72'(data2conv[3:0]), 72'(tbl[widx].t00));
                chk($sformatf("tbl t22 w%0d", widx), 72'(data2conv[35:32]), 72'(tbl[widx].t22));
                chk($sformatf("tbl ch1 t00 w%0d", widx), 72'(data2conv[39:36]), 72'(tbl[widx].c1t00));
                chk($sformatf("tbl last w%0d", widx), 72'(last_out), 72'(tbl[widx].last));
            end
            widx++;
        end else begin
            chk($sformatf("last_out idle p%0d", p), 72'(last_out), 72'(0));
        end
        for (int i = 0; i < idle; i++) begin
            @(posedge clk);
            #1;
            chk($sformatf("en_out bubble p%0d", p), 72'(en_out), 72'(0));
        end
    endtask

    task automatic run_frame(input int idle, input bit sof_first);
        widx = 0;
        for (int p = 0; p < 20; p++) begin
            send(p, sof_first && (p == 0), idle);
        end
        chk("window count", 72'(widx), 72'(6));
    endtask

    initial begin
        tbl[0] = '{12, 1'b0, 4'd0, 4'd12, 4'd15};
        tbl[1] = '{13, 1'b0, 4'd1, 4'd13, 4'd14};
        tbl[2] = '{14, 1'b0, 4'd2, 4'd14, 4'd13};
        tbl[3] = '{17, 1'b0, 4'd5, 4'd1,  4'd10};
        tbl[4] = '{18, 1'b0, 4'd6, 4'd2,  4'd9};
        tbl[5] = '{19, 1'b1, 4'd7, 4'd3,  4'd8};

        rst = 1'b1; d_in = '0; en_in = 1'b0; sof = 1'b0;
        d1 = '0; en1 = 1'b0; sof1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset en_out", 72'(en_out), 72'(0));
        chk("reset last_out", 72'(last_out), 72'(0));
        chk("reset data2conv", data2conv, 72'(0));
        chk("reset k1 data", 72'(data1), 72'(0));

        run_frame(0, 1'b0);
        run_frame(2, 1'b0);

        for (int p = 0; p < 9; p++) send(p, 1'b0, 0);
        rst = 1'b1; en_in = 1'b1; d_in = 8'hA5;
        @(posedge clk);
        #1;
        rst = 1'b0; en_in = 1'b0;
        chk("midreset en_out", 72'(en_out), 72'(0));
        chk("midreset last_out", 72'(last_out), 72'(0));
        chk("midreset data2conv", data2conv, 72'(0));
        run_frame(0, 1'b0);

        for (int p = 0; p < 8; p++) send(p, 1'b0, 0);
        run_frame(0, 1'b1);
        run_frame(0, 1'b0);

        for (int p = 0; p < 8; p++) begin
            logic [7:0] v;
            v = 8'($urandom);
            d1 = v; en1 = 1'b1;
            @(posedge clk);
            #1;
            en1 = 1'b0;
            chk($sformatf("k1 en_out p%0d", p), 72'(en_out1), 72'(1));
            chk($sformatf("k1 data p%0d", p), 72'(data1), 72'(v));
            chk($sformatf("k1 last p%0d", p), 72'(last_out1), 72'(p == 7));
            if (p == 3) begin
                @(posedge clk);
                #1;
                chk("k1 gap en_out", 72'(en_out1), 72'(0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
